// File: rtl/cpu_pkg.sv
// cpu_pkg: shared hazard-unit types and encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        FLUSH
    } hz_state_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control, E-stage forwarding selects and
// saturating stall/flush performance counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int         FLUSH_CYCLES = 1,
    parameter int         CNT_W        = 32,
    parameter logic [1:0] LOAD_SRC     = RESULT_LOAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemBusyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    hz_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       lu, accept;

    assign lu = ResultSrcE == LOAD_SRC && RegWriteE && RdE != 5'd0 &&
                (RdE == Rs1D || RdE == Rs2D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // WAIT decodes exactly like RUN: a stall while busy, RUN's decision on the exit cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        if (state_q == FLUSH) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            if (MemBusyM) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else begin
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
            end
        end else if (MemBusyM) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            state_d = WAIT;
        end else if (PCSrcE) begin
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            accept  = 1'b1;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
        end else begin
            state_d = RUN;
            StallF  = lu;
            StallD  = lu;
            FlushE  = lu;
        end
        // Reset clears the reset-less pipeline registers through their flush inputs.
        if (!rst_n) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            accept = 1'b0;
        end
    end

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst_n) begin
            ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? FWD_M :
                        (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? FWD_W : FWD_RF;
            ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? FWD_M :
                        (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? FWD_W : FWD_RF;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF),
        .count (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios then random traffic on two hazard_ctrl
// configurations, checked against a remaining-flush-cycles reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemBusyM;
    logic [1:0] ResultSrcE;

    logic [1:0]  sf, sd, se, fd, fe;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [31:0] sc0, fc0;
    logic [2:0]  sc1, fc1;

    int n_cmp = 0;
    int n_err = 0;

    int      fl[2];
    longint  scm[2], fcm[2];
    int      fcyc[2] = '{1, 3};
    longint  mx[2]   = '{64'hFFFF_FFFF, 7};

    hazard_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM),
        .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemBusyM(MemBusyM), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
        .FlushD(fd[0]), .FlushE(fe[0]), .ForwardAE(fa0), .ForwardBE(fb0),
        .StallCnt(sc0), .FlushCnt(fc0)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM),
        .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemBusyM(MemBusyM), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
        .FlushD(fd[1]), .FlushE(fe[1]), .ForwardAE(fa1), .ForwardBE(fb1),
        .StallCnt(sc1), .FlushCnt(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (!rst_n) return 2'd0;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    // One clock: check both DUTs at negedge against the model, then advance the model.
    task automatic cyc();
        bit     e_sf[2], e_sd[2], e_se[2], e_fd[2], e_fe[2], acc[2];
        int     fl_n[2];
        bit     lu;
        @(negedge clk);
        lu = ResultSrcE == 2'b01 && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        for (int i = 0; i < 2; i++) begin
            e_sf[i] = 0; e_sd[i] = 0; e_se[i] = 0; e_fd[i] = 0; e_fe[i] = 0; acc[i] = 0;
            fl_n[i] = fl[i];
            if (!rst_n) begin
                fl[i] = 0; fl_n[i] = 0; scm[i] = 0; fcm[i] = 0;
                e_fd[i] = 1; e_fe[i] = 1;
            end else if (fl[i] > 0) begin
                e_fd[i] = 1; e_fe[i] = 1;
                e_sf[i] = MemBusyM; e_sd[i] = MemBusyM; e_se[i] = MemBusyM;
                if (!MemBusyM) fl_n[i] = fl[i] - 1;
            end else if (MemBusyM) begin
                e_sf[i] = 1; e_sd[i] = 1; e_se[i] = 1;
            end else if (PCSrcE) begin
                e_fd[i] = 1; e_fe[i] = 1; acc[i] = 1;
                fl_n[i] = fcyc[i] - 1;
            end else if (lu) begin
                e_sf[i] = 1; e_sd[i] = 1; e_fe[i] = 1;
            end
            chk($sformatf("u%0d.StallF", i), 64'(sf[i]), 64'(e_sf[i]));
            chk($sformatf("u%0d.StallD", i), 64'(sd[i]), 64'(e_sd[i]));
            chk($sformatf("u%0d.StallE", i), 64'(se[i]), 64'(e_se[i]));
            chk($sformatf("u%0d.FlushD", i), 64'(fd[i]), 64'(e_fd[i]));
            chk($sformatf("u%0d.FlushE", i), 64'(fe[i]), 64'(e_fe[i]));
            chk($sformatf("u%0d.ForwardAE", i), 64'(i == 0 ? fa0 : fa1), 64'(fwd_exp(Rs1E)));
            chk($sformatf("u%0d.ForwardBE", i), 64'(i == 0 ? fb0 : fb1), 64'(fwd_exp(Rs2E)));
            chk($sformatf("u%0d.StallCnt", i), i == 0 ? 64'(sc0) : 64'(sc1), 64'(scm[i]));
            chk($sformatf("u%0d.FlushCnt", i), i == 0 ? 64'(fc0) : 64'(fc1), 64'(fcm[i]));
        end
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fl[i]  = fl_n[i];
                scm[i] = (scm[i] + e_sf[i] > mx[i]) ? mx[i] : scm[i] + e_sf[i];
                fcm[i] = (fcm[i] + acc[i] > mx[i]) ? mx[i] : fcm[i] + acc[i];
            end
        end
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MemBusyM = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin fl[i] = 0; scm[i] = 0; fcm[i] = 0; end
        idle();
        rst_n = 0;
        cyc();
        cyc();
        chk("rst.FlushE", 64'(fe[0]), 64'(1));
        chk("rst.StallF", 64'(sf[0]), 64'(0));
        rst_n = 1;
        cyc();

        // load-use on x5 through Rs2D
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs2D = 5;
        cyc();
        chk("lu.StallCnt", 64'(sc0), 64'(1));
        idle();
        cyc();
        chk("lu.once", 64'(sc0), 64'(1));

        // taken branch
        do_reset();
        PCSrcE = 1;
        cyc();
        PCSrcE = 0;
        cyc();
        cyc();
        chk("br.FlushCnt", 64'(fc1), 64'(1));
        cyc();
        chk("br.FlushD_done", 64'(fd[1]), 64'(0));

        // memory wait with a pending branch
        do_reset();
        MemBusyM = 1; PCSrcE = 1;
        repeat (4) cyc();
        MemBusyM = 0;
        cyc();
        chk("mw.StallCnt", 64'(sc0), 64'(4));
        chk("mw.FlushCnt", 64'(fc0), 64'(1));
        PCSrcE = 0;
        cyc();
        chk("mw.u0_idle", 64'(fd[0]), 64'(0));

        // reset in the middle of a multi-cycle flush
        do_reset();
        PCSrcE = 1;
        cyc();
        PCSrcE = 0; rst_n = 0;
        cyc();
        chk("rf.FlushD", 64'(fd[1]), 64'(1));
        chk("rf.StallF", 64'(sf[1]), 64'(0));
        chk("rf.FlushCnt", 64'(fc1), 64'(0));
        rst_n = 1;
        cyc();
        chk("rf.run", 64'(fd[1]), 64'(0));

        // forwarding priority and x0
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 0;
        cyc();
        chk("fw.AE_M", 64'(fa0), 64'(2));
        chk("fw.BE_x0", 64'(fb0), 64'(0));
        RdM = 0;
        cyc();
        chk("fw.AE_W", 64'(fa0), 64'(1));

        // saturation of the narrow counter
        do_reset();
        MemBusyM = 1;
        repeat (9) cyc();
        MemBusyM = 0;
        cyc();
        chk("sat.u1", 64'(sc1), 64'(7));
        chk("sat.u0", 64'(sc0), 64'(9));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 99) >= 2);
            Rs1D       = 5'($urandom_range(0, 7));
            Rs2D       = 5'($urandom_range(0, 7));
            Rs1E       = 5'($urandom_range(0, 7));
            Rs2E       = 5'($urandom_range(0, 7));
            RdE        = 5'($urandom_range(0, 7));
            RdM        = 5'($urandom_range(0, 7));
            RdW        = 5'($urandom_range(0, 7));
            RegWriteE  = 1'($urandom);
            RegWriteM  = 1'($urandom);
            RegWriteW  = 1'($urandom);
            ResultSrcE = 2'($urandom);
            PCSrcE     = ($urandom_range(0, 99) < 15);
            MemBusyM   = ($urandom_range(0, 99) < 20);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
